// File: rtl/seven_seg_capture_if.sv
// seven_seg_capture_if
// Frame output bus of the seven-segment capture block.
//   value     16  captured word, nibble i = digit i
//   err        4  err[i] set when digit i came from an unrecognised pattern
//   out_valid  1  value/err hold a completed frame
//   out_ready  1  consumer accepts the frame when out_valid & out_ready
//   overrun    1  sticky, a completed frame replaced one never accepted
// master = capture block (producer), slave = consumer.
interface seven_seg_capture_if;
  logic [15:0] value;
  logic [3:0]  err;
  logic        out_valid;
  logic        out_ready;
  logic        overrun;

  modport master (
    output value,
    output err,
    output out_valid,
    output overrun,
    input  out_ready
  );

  modport slave (
    input  value,
    input  err,
    input  out_valid,
    input  overrun,
    output out_ready
  );
endinterface

// File: rtl/seven_seg_capture.sv
// seven_seg_capture
// Watches a multiplexed, active-low 4-digit seven-segment bus and recovers
// the hex nibble shown on each digit. A digit is accepted once its pattern
// has been stable for STABLE_CYCLES samples; once all four digits are seen
// the word is presented on the frame bus with a valid/ready handshake.
// Ports:
//   clk    single clock, rising edge
//   rst_n  synchronous active-low reset
//   seg    segment lines, active-low, seg[6]=a .. seg[0]=g
//   an     digit anodes, active-low, an[i]=0 selects digit i
//   frame  frame output bus (value, err, out_valid, out_ready, overrun)
module seven_seg_capture #(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [6:0]                 seg,
  input  logic [3:0]                 an,
  seven_seg_capture_if.master        frame
);

  localparam logic [7:0] STABLE = 8'(STABLE_CYCLES);

  typedef enum logic {
    SETTLE,
    HOLD
  } state_t;

  state_t      state;
  logic [6:0]  seg_q;
  logic [3:0]  an_q;
  logic [6:0]  seg_prev;
  logic [3:0]  an_prev;
  logic [7:0]  count;
  logic [3:0]  seen;
  logic [15:0] slots;
  logic [3:0]  slot_err;

  logic        legal;
  logic [1:0]  sel;
  logic        same;
  logic        holding;
  logic [7:0]  count_next;
  logic        capture;
  logic [3:0]  nib;
  logic        bad;

  // Anode legality and digit index: exactly one anode may be low.
  always_comb begin
    legal = 1'b1;
    sel   = 2'd0;
    case (an_q)
      4'b1110: sel = 2'd0;
      4'b1101: sel = 2'd1;
      4'b1011: sel = 2'd2;
      4'b0111: sel = 2'd3;
      default: legal = 1'b0;
    endcase
  end

  // Stability tracking. While in HOLD the previous sample always equals the
  // captured (an, seg), so comparing against the previous sample is enough to
  // detect leaving the dwell. The counter cannot pass STABLE in SETTLE since
  // reaching it moves to HOLD.
  always_comb begin
    same       = (an_q == an_prev) && (seg_q == seg_prev);
    holding    = (state == HOLD) && same;
    count_next = 8'd1;
    if (holding)
      count_next = count;
    else if (!legal)
      count_next = 8'd0;
    else if (same)
      count_next = (count < STABLE) ? count + 8'd1 : STABLE;
    capture = legal && !holding && (count_next == STABLE);
  end

  // Active-low segment pattern to nibble; anything else flags an error.
  always_comb begin
    bad = 1'b0;
    nib = 4'h0;
    case (seg_q)
      7'h01: nib = 4'h0;
      7'h4F: nib = 4'h1;
      7'h12: nib = 4'h2;
      7'h06: nib = 4'h3;
      7'h4C: nib = 4'h4;
      7'h24: nib = 4'h5;
      7'h20: nib = 4'h6;
      7'h0F: nib = 4'h7;
      7'h00: nib = 4'h8;
      7'h04: nib = 4'h9;
      7'h08: nib = 4'hA;
      7'h60: nib = 4'hB;
      7'h31: nib = 4'hC;
      7'h42: nib = 4'hD;
      7'h30: nib = 4'hE;
      7'h38: nib = 4'hF;
      default: bad = 1'b1;
    endcase
  end

  // Sample stage, digit FSM, slot capture and frame handshake.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      seg_q           <= '1;
      an_q            <= '1;
      seg_prev        <= '1;
      an_prev         <= '1;
      count           <= 8'd0;
      state           <= SETTLE;
      seen            <= 4'b0000;
      slots           <= 16'h0000;
      slot_err        <= 4'b0000;
      frame.value     <= 16'h0000;
      frame.err       <= 4'b0000;
      frame.out_valid <= 1'b0;
      frame.overrun   <= 1'b0;
    end else begin
      seg_q    <= seg;
      an_q     <= an;
      seg_prev <= seg_q;
      an_prev  <= an_q;
      count    <= count_next;

      if (capture || holding)
        state <= HOLD;
      else
        state <= SETTLE;

      if (capture) begin
        slots[{sel, 2'b00} +: 4] <= nib;
        slot_err[sel]            <= bad;
      end

      // Completed set is consumed the cycle after the last capture; ~an_q is
      // the one-hot digit select whenever a capture is legal.
      seen <= ((seen == 4'b1111) ? 4'b0000 : seen) | (capture ? ~an_q : 4'b0000);

      if (seen == 4'b1111) begin
        frame.value     <= slots;
        frame.err       <= slot_err;
        frame.out_valid <= 1'b1;
        if (frame.out_valid && !frame.out_ready)
          frame.overrun <= 1'b1;
      end else if (frame.out_valid && frame.out_ready) begin
        frame.out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_seven_seg_capture.sv
// tb_seven_seg_capture
// Self-checking bench for seven_seg_capture: directed scenarios with fixed
// expected words, followed by random dwells scored against a dwell-level
// reference model of the display bus.
module tb_seven_seg_capture;
  localparam int STABLE = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] seg;
  logic [3:0] an;

  seven_seg_capture_if bus ();

  seven_seg_capture #(.STABLE_CYCLES(STABLE)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .seg   (seg),
    .an    (an),
    .frame (bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [6:0] seg_table [16] = '{7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
                                 7'h00, 7'h04, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38};

  // reference model: tracks the current run of identical pin patterns
  logic [3:0]  m_an;
  logic [6:0]  m_seg;
  int          m_len;
  bit          m_captured;
  logic [3:0]  m_seen;
  logic [15:0] m_slots;
  logic [3:0]  m_errs;
  int          m_frames;
  logic [19:0] exp_q [$];
  bit          scoreboard_on = 1'b0;
  int          frames_got = 0;
  logic [19:0] mon_exp;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  function automatic int digitOf(input logic [3:0] a);
    int d = -1;
    int zeros = 0;
    for (int i = 0; i < 4; i++)
      if (!a[i]) begin
        zeros++;
        d = i;
      end
    return (zeros == 1) ? d : -1;
  endfunction

  task automatic resetModel();
    m_an       = 4'hF;
    m_seg      = 7'h7F;
    m_len      = 0;
    m_captured = 1'b0;
    m_seen     = 4'h0;
    m_slots    = 16'h0;
    m_errs     = 4'h0;
    m_frames   = 0;
    exp_q.delete();
  endtask

  task automatic modelStep(input logic [3:0] a, input logic [6:0] s, input int n);
    int d;
    logic [3:0] nibble;
    logic bad;
    if (a == m_an && s == m_seg)
      m_len += n;
    else begin
      m_an       = a;
      m_seg      = s;
      m_len      = n;
      m_captured = 1'b0;
    end
    d = digitOf(a);
    if (d >= 0 && !m_captured && m_len >= STABLE) begin
      m_captured = 1'b1;
      nibble = 4'h0;
      bad    = 1'b1;
      for (int k = 0; k < 16; k++)
        if (seg_table[k] == s) begin
          nibble = 4'(k);
          bad    = 1'b0;
        end
      m_slots[d*4 +: 4] = nibble;
      m_errs[d]         = bad;
      m_seen[d]         = 1'b1;
      if (m_seen == 4'hF) begin
        if (scoreboard_on) begin
          exp_q.push_back({m_errs, m_slots});
          m_frames++;
        end
        m_seen = 4'h0;
      end
    end
  endtask

  // holds (a, s) on the pins for exactly n rising edges
  task automatic applyStimulus(input logic [3:0] a, input logic [6:0] s, input int n);
    modelStep(a, s, n);
    an  = a;
    seg = s;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic showDigit(input int d, input logic [6:0] s, input int n);
    logic [3:0] a;
    a = ~(4'b0001 << d);
    applyStimulus(a, s, n);
  endtask

  task automatic sendFrame(input logic [6:0] s0, input logic [6:0] s1,
                           input logic [6:0] s2, input logic [6:0] s3);
    showDigit(0, s0, 6);
    showDigit(1, s1, 6);
    showDigit(2, s2, 6);
    showDigit(3, s3, 6);
  endtask

  task automatic idle(input int n);
    applyStimulus(4'hF, 7'h7F, n);
  endtask

  task automatic ack();
    bus.out_ready = 1'b1;
    idle(1);
    bus.out_ready = 1'b0;
  endtask

  task automatic doReset();
    an    = 4'hF;
    seg   = 7'h7F;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    resetModel();
  endtask

  // scoreboard: every accepted frame must match the model's next frame
  always @(negedge clk) begin
    if (scoreboard_on && bus.out_valid && bus.out_ready) begin
      frames_got++;
      if (exp_q.size() == 0)
        checkOutput("rand_extra_frame", 32'd1, 32'd0);
      else begin
        mon_exp = exp_q.pop_front();
        checkOutput("rand_value", 32'(bus.value), 32'(mon_exp[15:0]));
        checkOutput("rand_err", 32'(bus.err), 32'(mon_exp[19:16]));
      end
    end
  end

  initial begin
    logic [3:0] ra;
    logic [6:0] rs;
    an            = 4'hF;
    seg           = 7'h7F;
    rst_n         = 1'b0;
    bus.out_ready = 1'b0;
    resetModel();
    @(posedge clk);
    doReset();
    checkOutput("reset_value", 32'(bus.value), 32'h0);
    checkOutput("reset_err", 32'(bus.err), 32'h0);
    checkOutput("reset_valid", 32'(bus.out_valid), 32'h0);
    checkOutput("reset_overrun", 32'(bus.overrun), 32'h0);

    // stable scan, out_valid one cycle after the last capture
    showDigit(0, 7'h4F, 6);
    showDigit(1, 7'h12, 6);
    showDigit(2, 7'h06, 6);
    showDigit(3, 7'h4C, 5);
    checkOutput("scan_valid_early", 32'(bus.out_valid), 32'h0);
    showDigit(3, 7'h4C, 1);
    checkOutput("scan_valid", 32'(bus.out_valid), 32'h1);
    checkOutput("scan_value", 32'(bus.value), 32'h4321);
    checkOutput("scan_err", 32'(bus.err), 32'h0);
    showDigit(3, 7'h4C, 4);
    idle(3);
    checkOutput("scan_valid_held", 32'(bus.out_valid), 32'h1);
    ack();
    checkOutput("scan_ack", 32'(bus.out_valid), 32'h0);

    // short dwell on digit 0 is ignored, a full dwell later completes
    showDigit(0, 7'h04, 3);
    showDigit(1, 7'h06, 6);
    showDigit(2, 7'h12, 6);
    showDigit(3, 7'h4F, 6);
    idle(3);
    checkOutput("short_no_frame", 32'(bus.out_valid), 32'h0);
    showDigit(0, 7'h04, 4);
    idle(2);
    checkOutput("short_late_valid", 32'(bus.out_valid), 32'h1);
    checkOutput("short_late_value", 32'(bus.value), 32'h1239);
    ack();

    // invalid pattern on digit 2
    sendFrame(7'h00, 7'h00, 7'h7F, 7'h00);
    idle(2);
    checkOutput("invalid_value", 32'(bus.value), 32'h8088);
    checkOutput("invalid_err", 32'(bus.err), 32'h4);
    ack();

    // illegal anode patterns never capture
    showDigit(1, 7'h0F, 6);
    showDigit(2, 7'h0F, 6);
    showDigit(3, 7'h0F, 6);
    applyStimulus(4'b1100, 7'h00, 10);
    checkOutput("illegal_two_low", 32'(bus.out_valid), 32'h0);
    applyStimulus(4'b1111, 7'h00, 10);
    checkOutput("illegal_none_low", 32'(bus.out_valid), 32'h0);
    showDigit(0, 7'h0F, 6);
    idle(2);
    checkOutput("illegal_then_value", 32'(bus.value), 32'h7777);
    checkOutput("illegal_then_err", 32'(bus.err), 32'h0);
    ack();

    // two frames without acceptance -> overrun
    sendFrame(7'h4F, 7'h4F, 7'h4F, 7'h4F);
    idle(2);
    checkOutput("hs_first_value", 32'(bus.value), 32'h1111);
    checkOutput("hs_first_overrun", 32'(bus.overrun), 32'h0);
    sendFrame(7'h12, 7'h12, 7'h12, 7'h12);
    idle(2);
    checkOutput("hs_second_value", 32'(bus.value), 32'h2222);
    checkOutput("hs_second_valid", 32'(bus.out_valid), 32'h1);
    checkOutput("hs_overrun", 32'(bus.overrun), 32'h1);
    ack();
    checkOutput("hs_ack_valid", 32'(bus.out_valid), 32'h0);
    checkOutput("hs_overrun_sticky", 32'(bus.overrun), 32'h1);

    // reset after three captures discards them
    showDigit(0, 7'h4C, 6);
    showDigit(1, 7'h4C, 6);
    showDigit(2, 7'h4C, 6);
    doReset();
    checkOutput("midrst_value", 32'(bus.value), 32'h0);
    checkOutput("midrst_err", 32'(bus.err), 32'h0);
    checkOutput("midrst_valid", 32'(bus.out_valid), 32'h0);
    checkOutput("midrst_overrun", 32'(bus.overrun), 32'h0);
    showDigit(3, 7'h06, 6);
    idle(2);
    checkOutput("midrst_partial", 32'(bus.out_valid), 32'h0);
    showDigit(0, 7'h06, 6);
    showDigit(1, 7'h06, 6);
    showDigit(2, 7'h06, 6);
    idle(2);
    checkOutput("midrst_full_value", 32'(bus.value), 32'h3333);

    // completion in the same cycle as acceptance: no overrun
    showDigit(0, 7'h4C, 6);
    showDigit(1, 7'h4C, 6);
    showDigit(2, 7'h4C, 6);
    showDigit(3, 7'h4C, 5);
    bus.out_ready = 1'b1;
    showDigit(3, 7'h4C, 1);
    checkOutput("simul_valid", 32'(bus.out_valid), 32'h1);
    checkOutput("simul_value", 32'(bus.value), 32'h4444);
    checkOutput("simul_overrun", 32'(bus.overrun), 32'h0);
    showDigit(3, 7'h4C, 1);
    checkOutput("simul_drop", 32'(bus.out_valid), 32'h0);
    bus.out_ready = 1'b0;

    // random dwells against the reference model
    doReset();
    bus.out_ready = 1'b1;
    scoreboard_on = 1'b1;
    for (int t = 0; t < 150; t++) begin
      ra = ~(4'b0001 << $urandom_range(0, 3));
      if ($urandom_range(0, 9) == 0) ra = 4'($urandom);
      if ($urandom_range(0, 7) == 0) rs = 7'($urandom);
      else rs = seg_table[$urandom_range(0, 15)];
      applyStimulus(ra, rs, $urandom_range(1, 8));
    end
    idle(10);
    scoreboard_on = 1'b0;
    checkOutput("rand_frame_count", 32'(frames_got), 32'(m_frames));
    checkOutput("rand_pending", 32'(exp_q.size()), 32'h0);
    checkOutput("rand_overrun", 32'(bus.overrun), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
